ft2232h_tx_fifo: RTL and testbench

Parametrised successor to the fixed-pattern FT2232H transmitter. It buffers a valid/ready upstream stream in an internal FIFO and drains it onto the FT245-style synchronous FIFO bus (TXE#/WR#/data), one word per clock. It honours TXE# back-pressure without losing or duplicating words. It sits between the system data path and the FT2232H pads, clocked by the FT2232H 60 MHz CLKOUT.

---
 rtl/ft2232h_tx_fifo_if.sv | 33 +++
 rtl/ft2232h_tx_fifo.sv | 179 +++++++++++++++++
 tb/tb_ft2232h_tx_fifo.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft2232h_tx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : ft2232h_tx_fifo_if
//  Purpose  : Bundles the upstream valid/ready stream and the FT245-style
//             synchronous FIFO bus (TXE#/WR#/data/SIWU#) of ft2232h_tx_fifo.
//  Ports    : in_data/in_valid/in_ready - upstream word stream
//             txe_n/wr_n/data_out/siwu_n - FT2232H pad-side bus
//  Modports : slave  - the transmitter block
//             master - everything around it (upstream source and device)
//  Revision : 1.0 - initial release
// ============================================================================
interface ft2232h_tx_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  txe_n;
  logic                  wr_n;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  siwu_n;

  modport slave (
    input  in_data, in_valid, txe_n,
    output in_ready, wr_n, data_out, siwu_n
  );

  modport master (
    output in_data, in_valid, txe_n,
    input  in_ready, wr_n, data_out, siwu_n
  );
endinterface
`default_nettype wire

// File: rtl/ft2232h_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ft2232h_tx_fifo
//  Purpose  : Buffers an upstream valid/ready stream in a DEPTH-entry FIFO
//             plus one output register and drains it onto the FT2232H
//             synchronous FIFO bus, one word per CLKOUT edge, honouring TXE#.
//  Ports    : clk      - FT2232H CLKOUT, rising edge
//             reset_n  - asynchronous active-low reset
//             enable   - 1 allows bus writes, 0 holds the bus idle
//             bus      - ft2232h_tx_fifo_if.slave (stream + pad bus)
//             level    - words held (FIFO + output stage), registered
//  Options  : `define FT2232H_TX_SIWU_EN builds the SIWU# flush generator;
//             otherwise siwu_n is tied high.
//  Revision : 1.0 - initial release
// ============================================================================
module ft2232h_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FLUSH_IDLE = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  ft2232h_tx_fifo_if.slave       bus,
  output logic [$clog2(DEPTH):0] level
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_LVL_W  = c_ADDR_W + 1;
  localparam logic [c_LVL_W-1:0] c_CAP = c_LVL_W'(DEPTH + 1);

  // "Loaded" is resolved on the load edge itself: a freshly loaded word goes
  // straight to WRITE or HOLD depending on enable, so LOADED is never resident.
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_WRITE = 2'd1;
  localparam logic [1:0] c_ST_HOLD  = 2'd2;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_ADDR_W:0]     r_wr_ptr;
  logic [c_ADDR_W:0]     r_wr_ptr_vis;
  logic [c_ADDR_W:0]     r_rd_ptr;
  logic [1:0]            r_state;
  logic                  r_wr_n;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [c_LVL_W-1:0]    r_level;
  logic                  r_in_ready;

  logic [1:0]            w_state_next;
  logic                  w_wr_n_next;
  logic                  w_out_valid;
  logic                  w_push;
  logic                  w_xfer;
  logic                  w_fifo_avail;
  logic                  w_load;
  logic [c_LVL_W-1:0]    w_level_next;

  // The output stage holds a word in every state except IDLE.
  assign w_out_valid  = (r_state != c_ST_IDLE);
  assign w_push       = bus.in_valid & r_in_ready;
  assign w_xfer       = ~r_wr_n & ~bus.txe_n;
  // The read side sees the write pointer one clk late, which gives the
  // two-clk push-to-bus latency and keeps the head read off the word being
  // written on the same edge.
  assign w_fifo_avail = (r_wr_ptr_vis != r_rd_ptr);
  assign w_load       = w_fifo_avail & (~w_out_valid | w_xfer);
  assign w_level_next = r_level + {{c_ADDR_W{1'b0}}, w_push}
                                - {{c_ADDR_W{1'b0}}, w_xfer};

  // Storage array carries no reset; pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= bus.in_data;
    end
  end

  // State register plus the registered bus-side outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_ST_IDLE;
      r_wr_n       <= 1'b1;
      r_data_out   <= '0;
      r_level      <= '0;
      r_in_ready   <= 1'b0;
      r_wr_ptr     <= '0;
      r_wr_ptr_vis <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_wr_n       <= w_wr_n_next;
      r_level      <= w_level_next;
      r_in_ready   <= (w_level_next < c_CAP);
      r_wr_ptr_vis <= r_wr_ptr;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_load) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= r_mem[r_rd_ptr[c_ADDR_W-1:0]];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_load) begin
          w_state_next = enable ? c_ST_WRITE : c_ST_HOLD;
        end
      end
      c_ST_WRITE: begin
        // A transfer on the edge enable drops still completes; only the
        // following word is held back.
        if (w_xfer && !w_load) begin
          w_state_next = c_ST_IDLE;
        end else if (!enable) begin
          w_state_next = c_ST_HOLD;
        end
      end
      c_ST_HOLD: begin
        if (enable) begin
          w_state_next = c_ST_WRITE;
        end
      end
      default: w_state_next = c_ST_IDLE;
    endcase
  end

  // Output logic: WR# is asserted for exactly the cycles spent in WRITE.
  always_comb begin
    w_wr_n_next = (w_state_next != c_ST_WRITE);
  end

  assign bus.wr_n     = r_wr_n;
  assign bus.data_out = r_data_out;
  assign bus.in_ready = r_in_ready;
  assign level        = r_level;

`ifdef FT2232H_TX_SIWU_EN
  localparam int c_CNT_W = $clog2(FLUSH_IDLE + 1);

  logic [c_CNT_W-1:0] r_idle_cnt;
  logic               r_armed;
  logic               r_siwu_n;

  // One SIWU# pulse per burst: armed by a transfer, fired after FLUSH_IDLE
  // consecutive empty, push-free clks, then disarmed until the next transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idle_cnt <= '0;
      r_armed    <= 1'b0;
      r_siwu_n   <= 1'b1;
    end else begin
      r_siwu_n <= 1'b1;
      if (w_xfer) begin
        r_armed <= 1'b1;
      end
      if (w_push || (r_level != '0)) begin
        r_idle_cnt <= '0;
      end else if (r_armed) begin
        if (r_idle_cnt == c_CNT_W'(FLUSH_IDLE - 1)) begin
          r_siwu_n   <= 1'b0;
          r_armed    <= 1'b0;
          r_idle_cnt <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.siwu_n = r_siwu_n;
`else
  assign bus.siwu_n = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ft2232h_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ft2232h_tx_fifo
//  Purpose  : Self-checking bench for ft2232h_tx_fifo (DEPTH=16, 8-bit).
//             A queue-based reference model predicts wr_n, data_out, level,
//             in_ready and siwu_n every cycle; a device-side sink checks
//             end-to-end ordering; directed phases pin literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ft2232h_tx_fifo;
  localparam int DW         = 8;
  localparam int DEPTH      = 16;
  localparam int FLUSH_IDLE = 16;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic [4:0] level;

  ft2232h_tx_fifo_if #(.DATA_WIDTH(DW)) bus ();

  ft2232h_tx_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .FLUSH_IDLE (FLUSH_IDLE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .bus     (bus),
    .level   (level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [7:0] d; int c; } ent_t;
  ent_t       m_q[$];
  logic [7:0] sb_q[$];
  logic       m_ov = 1'b0, m_wr_n = 1'b1, m_in_ready = 1'b0;
  logic       m_siwu_n = 1'b1, m_armed = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_level = 0, m_idle = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete(); sb_q.delete();
      m_ov = 1'b0; m_data = 8'h00; m_wr_n = 1'b1; m_level = 0;
      m_in_ready = 1'b0; m_siwu_n = 1'b1; m_armed = 1'b0; m_idle = 0;
    end else begin : model_step
      bit push, xfer;
      push = bus.in_valid && m_in_ready;
      xfer = !m_wr_n && !bus.txe_n;
      m_siwu_n = 1'b1;
      if (push || m_level != 0) m_idle = 0; else m_idle++;
      if (xfer) m_armed = 1'b1;
      if (m_armed && m_idle == FLUSH_IDLE) begin
        m_siwu_n = 1'b0;
        m_armed  = 1'b0;
      end
      if (xfer) m_ov = 1'b0;
      // A pushed word becomes presentable two edges after its push edge.
      if (!m_ov && m_q.size() > 0 && cyc >= m_q[0].c + 2) begin
        m_data = m_q[0].d;
        void'(m_q.pop_front());
        m_ov = 1'b1;
      end
      if (push) begin
        m_q.push_back('{bus.in_data, cyc});
        sb_q.push_back(bus.in_data);
      end
      m_level    = m_q.size() + (m_ov ? 1 : 0);
      m_in_ready = (m_level < DEPTH + 1);
      m_wr_n     = !(m_ov && enable);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_n", {31'b0, bus.wr_n}, {31'b0, m_wr_n});
      check("data_out", {24'b0, bus.data_out}, {24'b0, m_data});
      check("level", {27'b0, level}, m_level);
      check("in_ready", {31'b0, bus.in_ready}, {31'b0, m_in_ready});
`ifdef FT2232H_TX_SIWU_EN
      check("siwu_n", {31'b0, bus.siwu_n}, {31'b0, m_siwu_n});
`else
      check("siwu_n", {31'b0, bus.siwu_n}, 32'd1);
`endif
    end
  end

  // ---------------- device-side sink ----------------
  logic [7:0] sink_q[$];
  int         sink_c[$];

  always @(posedge clk) begin
    if (reset_n && !bus.wr_n && !bus.txe_n) begin
      sink_q.push_back(bus.data_out);
      sink_c.push_back(cyc);
      if (sb_q.size() == 0) check("sb_extra_word", {24'b0, bus.data_out}, 32'hFFFF_FFFF);
      else check("sb_order", {24'b0, bus.data_out}, {24'b0, sb_q.pop_front()});
    end
  end

  task automatic sink_clear();
    sink_q.delete();
    sink_c.delete();
  endtask

  task automatic wait_sink(input int n, input int budget, input string name);
    int k = 0;
    while (sink_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, sink_q.size(), n);
  endtask

  task automatic push_seq(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = base + 8'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n0, acc, pulses, t_zero, t_pulse, k;
    bit seen_nz, stalled;
    logic       wr_h [1:16];
    logic [7:0] dat_h[1:16];

    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.txe_n = 1'b1;
    enable = 1'b0; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;

    // Reset release: in_ready rises one clk after release, bus stays idle.
    bus.txe_n = 1'b0; enable = 1'b1; reset_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rel_wr_n", {31'b0, bus.wr_n}, 32'd1);
    check("rel_level", {27'b0, level}, 32'd0);

    // Streaming 0x01..0x10.
    sink_clear();
    n0 = cyc;
    for (int i = 1; i <= 16; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(i);
      @(negedge clk);
      wr_h[i] = bus.wr_n; dat_h[i] = bus.data_out;
    end
    bus.in_valid = 1'b0;
    check("stream_wr_n_e1", {31'b0, wr_h[1]}, 32'd1);
    check("stream_wr_n_e2", {31'b0, wr_h[2]}, 32'd1);
    check("stream_wr_n_e3", {31'b0, wr_h[3]}, 32'd0);
    check("stream_first_data", {24'b0, dat_h[3]}, 32'h01);
    wait_sink(16, 60, "stream_count");
    for (int i = 0; i < 16 && i < sink_q.size(); i++) begin
      check("stream_data", {24'b0, sink_q[i]}, i + 1);
      check("stream_cycle", sink_c[i], n0 + 3 + i);
    end
    repeat (4) @(negedge clk);

    // Back-pressure at 0x07.
    sink_clear();
    fork
      push_seq(8'h01, 16);
      begin
        stalled = 1'b0;
        for (int j = 0; j < 60 && !stalled; j++) begin
          @(negedge clk);
          if (bus.data_out == 8'h07 && bus.wr_n == 1'b0) begin
            stalled = 1'b1;
            bus.txe_n = 1'b1;
            for (int s = 0; s < 5; s++) begin
              @(negedge clk);
              check("bp_wr_n_held", {31'b0, bus.wr_n}, 32'd0);
              check("bp_data_held", {24'b0, bus.data_out}, 32'h07);
            end
            bus.txe_n = 1'b0;
          end
        end
        check("bp_stall_seen", {31'b0, stalled}, 32'd1);
      end
    join
    wait_sink(16, 60, "bp_count");
    for (int i = 0; i < 16 && i < sink_q.size(); i++)
      check("bp_data", {24'b0, sink_q[i]}, i + 1);
    repeat (4) @(negedge clk);

    // Full: 20 offered with TXE# high, 17 accepted.
    sink_clear();
    bus.txe_n = 1'b1;
    acc = 0;
    for (int i = 1; i <= 20; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'h40 + 8'(i);
      if (bus.in_ready) acc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("full_accepted", acc, 17);
    check("full_level", {27'b0, level}, 32'd17);
    check("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.txe_n = 1'b0;
    wait_sink(17, 60, "full_drain_count");
    repeat (10) @(negedge clk);
    check("full_exact_count", sink_q.size(), 17);
    for (int i = 0; i < 17 && i < sink_q.size(); i++)
      check("full_data", {24'b0, sink_q[i]}, 32'h41 + i);

    // Enable gating with 4 words buffered.
    sink_clear();
    enable = 1'b0;
    push_seq(8'hA0, 4);
    repeat (6) @(negedge clk);
    check("gate_wr_n", {31'b0, bus.wr_n}, 32'd1);
    check("gate_level", {27'b0, level}, 32'd4);
    check("gate_no_xfer", sink_q.size(), 0);
    enable = 1'b1;
    wait_sink(4, 20, "gate_count");
    repeat (3) @(negedge clk);
    check("gate_wr_n_after", {31'b0, bus.wr_n}, 32'd1);
    check("gate_level_after", {27'b0, level}, 32'd0);
    for (int i = 0; i < 4 && i < sink_q.size(); i++)
      check("gate_data", {24'b0, sink_q[i]}, 32'hA0 + i);

    // Reset mid-burst: asynchronous WR# release, buffered words discarded.
    bus.txe_n = 1'b1;
    push_seq(8'hC0, 5);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("arst_wr_n", {31'b0, bus.wr_n}, 32'd1);
    check("arst_level", {27'b0, level}, 32'd0);
    check("arst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    sink_clear();
    bus.txe_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("arst_rel_in_ready", {31'b0, bus.in_ready}, 32'd1);
    repeat (10) @(negedge clk);
    check("arst_no_spurious", sink_q.size(), 0);

    // Randomised traffic in four density regimes.
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 700; i++) begin
        bus.in_valid = ($urandom_range(3) < 3 - seg) || (seg == 3 && $urandom_range(1) == 0);
        bus.in_data  = 8'($urandom);
        bus.txe_n    = ($urandom_range(7) < 2 + seg);
        enable       = ($urandom_range(9) != 0);
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b0; bus.txe_n = 1'b0; enable = 1'b1;
    repeat (60) @(negedge clk);
    check("drain_level", {27'b0, level}, 32'd0);
    check("drain_scoreboard", sb_q.size(), 0);

    // SIWU#: one word transferred, then idle.
    pulses = 0; t_zero = -1; t_pulse = -1; seen_nz = 1'b0;
    push_seq(8'h5A, 1);
    k = 0;
    while (k < 60) begin
      if (level != 0) seen_nz = 1'b1;
      else if (seen_nz && t_zero < 0) t_zero = cyc;
      if (bus.siwu_n == 1'b0) begin
        pulses++;
        t_pulse = cyc;
      end
      @(negedge clk);
      k++;
    end
`ifdef FT2232H_TX_SIWU_EN
    check("siwu_pulses", pulses, 1);
    check("siwu_delay", t_pulse - t_zero, FLUSH_IDLE);
`else
    check("siwu_pulses", pulses, 0);
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
